// File: rtl/pwm_duty_ramp_ctrl_pkg.sv
// Shared types and default widths for the PWM control path.
// The PWM counter and the SPI register file use the same defaults.
package pwm_ctrl_pkg;
  localparam int DUTY_W_DEF = 8;
  localparam int DIV_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_ALIGN = 2'd2
  } state_e;
endpackage

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Duty-update bus between the SPI register file (master) and the ramp controller (slave).
interface pwm_duty_ramp_ctrl_if
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
);
  logic              duty_wr;
  logic [DUTY_W-1:0] duty_wdata;
  logic              ramp_en;
  logic [DUTY_W-1:0] step_size;
  logic [DIV_W-1:0]  step_div;
  logic              period_end;
  logic [DUTY_W-1:0] duty_out;
  logic              busy;
  logic              done;

  modport master (
    output duty_wr, duty_wdata, ramp_en, step_size, step_div, period_end,
    input  duty_out, busy, done
  );

  modport slave (
    input  duty_wr, duty_wdata, ramp_en, step_size, step_div, period_end,
    output duty_out, busy, done
  );
endinterface

// File: rtl/pwm_duty_ramp_ctrl_step_prescaler.sv
// Step-interval counter: counts while enabled and flags the cycle a ramp step is due.
module step_prescaler
  import pwm_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);
  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_q, cnt_d, last;

  // A divider of 0 behaves as 1; >= lets a live shrink of step_div fire at once
  // instead of waiting for the counter to wrap.
  assign last   = (div_i == '0) ? '0 : div_i - ONE;
  assign tick_o = en_i && (cnt_q >= last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Sequences duty-cycle updates into the PWM block, either as a jump or a rate-limited
// ramp, committing every change to the applied duty only on a PWM period boundary.
module pwm_duty_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int                 DUTY_W     = DUTY_W_DEF,
  parameter int                 DIV_W      = DIV_W_DEF,
  parameter logic [DUTY_W-1:0]  RESET_DUTY = '0
) (
  input logic                 clk,
  input logic                 rst,
  pwm_duty_ramp_ctrl_if.slave bus
);
  localparam logic [DUTY_W-1:0] ONE = {{(DUTY_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] next_q, next_d;
  logic              mode_q, mode_d;
  logic              busy_q, done_q, done_d;
  logic              pre_clr, pre_en, tick;
  logic [DUTY_W-1:0] eff_step;

  // Distance is taken one bit wider so it never wraps; result never passes the target.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt,
                                                    input logic [DUTY_W-1:0] stp);
    logic [DUTY_W:0] diff;
    diff = (tgt >= cur) ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
    if (diff <= {1'b0, stp}) return tgt;
    else if (tgt > cur)      return cur + stp;
    else                     return cur - stp;
  endfunction

  assign eff_step = (bus.step_size == '0) ? ONE : bus.step_size;

  step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (pre_clr),
    .en_i   (pre_en),
    .div_i  (bus.step_div),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    next_d   = next_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    pre_clr  = 1'b0;
    pre_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.duty_wr && (bus.duty_wdata != duty_q)) begin
          target_d = bus.duty_wdata;
          mode_d   = bus.ramp_en;
          if (!bus.ramp_en) begin
            next_d  = bus.duty_wdata;
            state_d = ST_ALIGN;
          end else begin
            pre_clr = 1'b1;
            state_d = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        pre_en = 1'b1;
        if (bus.duty_wr) begin
          target_d = bus.duty_wdata;
          mode_d   = bus.ramp_en;
        end
        if (tick) begin
          next_d  = mode_d ? step_toward(duty_q, target_d, eff_step) : target_d;
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        // Retarget is folded in before the commit so done compares against the new target.
        if (bus.duty_wr) begin
          target_d = bus.duty_wdata;
          mode_d   = bus.ramp_en;
          if (!bus.ramp_en) next_d = bus.duty_wdata;
        end
        if (bus.period_end) begin
          duty_d = next_d;
          if (next_d == target_d) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pre_clr = 1'b1;
            state_d = ST_RAMP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      duty_q   <= RESET_DUTY;
      target_q <= RESET_DUTY;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    next_q <= next_d;
    mode_q <= mode_d;
  end

  assign bus.duty_out = duty_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Scoreboard bench for pwm_duty_ramp_ctrl: directed scenarios then randomized traffic.
module tb_pwm_duty_ramp_ctrl;
  localparam int DW = 8;
  localparam int VW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_duty_ramp_ctrl_if #(.DUTY_W(DW), .DIV_W(VW)) bus ();

  pwm_duty_ramp_ctrl #(.DUTY_W(DW), .DIV_W(VW), .RESET_DUTY(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [DW-1:0] duty;
    logic          done;
    logic          busy;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  // Reference model: phase 0 idle, 1 waiting for step interval, 2 waiting for period end
  int m_phase = 0, m_duty = 0, m_target = 0, m_next = 0, m_k = 0;
  bit m_ramp = 1'b0;

  logic [DW-1:0] ss = 8'h10;
  logic [VW-1:0] sd = 16'd3;
  int            pe_per = 8;
  int            cyc_n = 0;

  function automatic int approach(input int cur, input int tgt, input int s);
    if (tgt > cur) return (cur + s > tgt) ? tgt : cur + s;
    else           return (cur - s < tgt) ? tgt : cur - s;
  endfunction

  task automatic model(input bit r, input bit wr, input int wd, input bit ren, input bit pe,
                       input int s_sz, input int s_dv);
    int   eff_s, eff_d, old_duty;
    bit   old_busy, done_n;
    exp_t e;
    eff_s    = (s_sz == 0) ? 1 : s_sz;
    eff_d    = (s_dv == 0) ? 1 : s_dv;
    old_duty = m_duty;
    old_busy = (m_phase != 0);
    done_n   = 1'b0;
    if (r) begin
      m_phase = 0; m_duty = 0; m_target = 0;
    end else if (m_phase == 0) begin
      if (wr && wd != m_duty) begin
        m_target = wd; m_ramp = ren;
        if (!ren) begin m_next = wd; m_phase = 2; end
        else begin m_k = 0; m_phase = 1; end
      end
    end else if (m_phase == 1) begin
      if (wr) begin m_target = wd; m_ramp = ren; end
      m_k++;
      if (m_k >= eff_d) begin
        m_next  = m_ramp ? approach(m_duty, m_target, eff_s) : m_target;
        m_phase = 2;
      end
    end else begin
      if (wr) begin
        m_target = wd; m_ramp = ren;
        if (!ren) m_next = wd;
      end
      if (pe) begin
        m_duty = m_next;
        if (m_duty == m_target) begin done_n = 1'b1; m_phase = 0; end
        else begin m_k = 0; m_phase = 1; end
      end
    end
    if (m_duty != old_duty || done_n || ((m_phase != 0) != old_busy)) begin
      e.duty = m_duty[DW-1:0];
      e.done = done_n;
      e.busy = (m_phase != 0);
      q.push_back(e);
    end
  endtask

  task automatic cyc(input bit r, input bit wr, input logic [DW-1:0] wd, input bit ren,
                     input bit pe_f);
    bit pe;
    @(negedge clk);
    pe = pe_f || (pe_per != 0 && (cyc_n % pe_per) == pe_per - 1);
    rst = r;
    bus.duty_wr = wr; bus.duty_wdata = wd; bus.ramp_en = ren; bus.period_end = pe;
    bus.step_size = ss; bus.step_div = sd;
    model(r, wr, int'(wd), ren, pe, int'(ss), int'(sd));
    cyc_n++;
  endtask

  task automatic run_idle(input int max);
    int n;
    n = 0;
    while (m_phase != 0 && n < max) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    tests++;
    if (m_phase != 0) begin
      fails++;
      $display("FAIL timeout: controller still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: any visible output change is a transaction to be matched in order
  initial begin
    logic [DW-1:0] pd;
    logic          pb;
    exp_t          e;
    wait (mon_en);
    pd = bus.duty_out;
    pb = bus.busy;
    forever begin
      @(posedge clk); #1;
      if (bus.duty_out !== pd || bus.done !== 1'b0 || bus.busy !== pb) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got duty=%h done=%b busy=%b, expected no change",
                   bus.duty_out, bus.done, bus.busy);
        end else begin
          e = q.pop_front();
          if ({bus.duty_out, bus.done, bus.busy} !== e) begin
            fails++;
            $display("FAIL event: got duty=%h done=%b busy=%b, expected duty=%h done=%b busy=%b",
                     bus.duty_out, bus.done, bus.busy, e.duty, e.done, e.busy);
          end
        end
      end
      pd = bus.duty_out;
      pb = bus.busy;
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.duty_wr = 1'b0; bus.duty_wdata = '0; bus.ramp_en = 1'b0; bus.period_end = 1'b0;
    bus.step_size = ss; bus.step_div = sd;

    // Reset
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("reset_duty", int'(bus.duty_out), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    cyc(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("reset_with_wr_busy", int'(bus.busy), 0);
    chk("reset_with_wr_duty", int'(bus.duty_out), 0);
    mon_en = 1'b1;

    // Jump to 0x80, then back to 0x00
    cyc(1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
    run_idle(200);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    run_idle(200);

    // Ramp up 0x00 -> 0x30, then down to 0x05, then unit steps
    ss = 8'h10; sd = 16'd3;
    cyc(1'b0, 1'b1, 8'h30, 1'b1, 1'b0);
    run_idle(500);
    cyc(1'b0, 1'b1, 8'h05, 1'b1, 1'b0);
    run_idle(500);
    ss = 8'h00; sd = 16'd0;
    cyc(1'b0, 1'b1, 8'h09, 1'b1, 1'b0);
    run_idle(500);

    // Retarget to 0x00 in ALIGN on the same cycle as period_end
    ss = 8'h10; sd = 16'd3;
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    run_idle(200);
    cyc(1'b0, 1'b1, 8'h30, 1'b1, 1'b0);
    n = 0;
    while (!(m_duty == 8'h10 && m_phase == 2) && n < 300) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    chk("retarget_reach_align", int'(m_duty == 8'h10 && m_phase == 2), 1);
    cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    run_idle(500);

    // Write equal to duty_out in idle is ignored
    cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset while a jump to 0x40 waits in ALIGN, then period ends change nothing
    cyc(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
    run_idle(200);
    cyc(1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic with live step changes and sporadic resets
    pe_per = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [DW-1:0] wd;
      bit            wr, ren, pe_f, r;
      if ($urandom_range(0, 39) == 0) ss = 8'($urandom_range(0, 40));
      if ($urandom_range(0, 39) == 0) sd = 16'($urandom_range(0, 6));
      wr   = ($urandom_range(0, 14) == 0);
      wd   = ($urandom_range(0, 3) == 0) ? 8'(m_duty) : 8'($urandom_range(0, 255));
      ren  = 1'($urandom_range(0, 1));
      pe_f = ($urandom_range(0, 4) == 0);
      r    = ($urandom_range(0, 499) == 0);
      cyc(r, wr, wd, ren, pe_f);
    end

    // Drain and confirm every expected event was seen
    pe_per = 4;
    run_idle(20000);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("scoreboard_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_duty_ramp_ctrl.md
# pwm_duty_ramp_ctrl

Controller that sequences duty-cycle updates into the PWM peripheral. It sits between the SPI register file's duty-cycle write and the `pwm_duty_cycle` input of the PWM block. A new target is applied either immediately or as a rate-limited ramp. Every change to the applied duty is committed only on a PWM period boundary, so no output period is ever truncated or glitched.

## Interface
Parameters:
- `DUTY_W`, 8: duty-cycle width.
- `DIV_W`, 16: step-interval counter width.
- `RESET_DUTY`, 0: duty applied out of reset.

Ports:
- `clk`, in, 1: single system clock; all logic on rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `duty_wr`, in, 1: one-cycle pulse; SPI register write of the duty register.
- `duty_wdata`, in, DUTY_W: new target duty, valid with `duty_wr`.
- `ramp_en`, in, 1: 1 = ramp toward target; 0 = jump to target. Sampled with `duty_wr`.
- `step_size`, in, DUTY_W: duty change per step. 0 is treated as 1.
- `step_div`, in, DIV_W: `clk` cycles between steps. 0 is treated as 1.
- `period_end`, in, 1: one-cycle pulse from the PWM counter on its last count of each period.
- `duty_out`, out, DUTY_W: applied duty; drives the PWM duty input.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done`, out, 1: one-cycle pulse when `duty_out` reaches the target.

## Operation
- Registers:
  - `state`: IDLE / RAMP / ALIGN.
  - `target` (DUTY_W).
  - `next_duty` (DUTY_W).
  - `div_cnt` (DIV_W).
  - `ramp_mode` (1).
- Reset: `state`=IDLE, `duty_out`=RESET_DUTY, `target`=RESET_DUTY, `div_cnt`=0, `busy`=0, `done`=0.
- IDLE:
  - On `duty_wr` with `duty_wdata`≠`duty_out`: latch `target` and `ramp_mode`.
  - If `ramp_mode`=0: `next_duty`←`duty_wdata`, go to ALIGN.
  - Otherwise: `div_cnt`←0, go to RAMP.
  - On `duty_wr` with `duty_wdata`=`duty_out`: no state change, no `done`.
- RAMP:
  - `div_cnt` increments each cycle.
  - The step fires on the cycle `div_cnt`=eff_div−1, where eff_div = max(`step_div`,1).
  - On the step: compute `next_duty`, go to ALIGN.
- Step arithmetic:
  - Compute |`target`−`duty_out`| in DUTY_W+1 bits; no wrap.
  - If the difference ≤ eff_step: `next_duty`=`target`.
  - Otherwise: `next_duty` = `duty_out` ± eff_step, toward `target`.
  - Never overshoots, never wraps past 0 or 2^DUTY_W−1.
- ALIGN: on `period_end`, `duty_out`←`next_duty`.
  - If `next_duty`=`target`: pulse `done`, go to IDLE.
  - Otherwise: `div_cnt`←0, go to RAMP.
- Retarget (`duty_wr` in RAMP or ALIGN):
  - `target` and `ramp_mode` are updated.
  - In RAMP, `div_cnt` continues.
  - In ALIGN, the pending `next_duty` is still committed.
  - If the new `ramp_mode`=0 in ALIGN: `next_duty`←new target.
  - Step direction is recomputed at every step.
- `duty_wr` and `period_end` in the same ALIGN cycle: the retarget is taken first (including the `ramp_mode`=0 override), then commit.
  - The done/RAMP decision compares against the new target.
- `period_end` outside ALIGN: ignored.
- `step_size` and `step_div` are read live; a change takes effect at the next step.

## Timing
- `duty_out`, `busy`, `done` are registered outputs; no combinational path from any input.
- Jump mode:
  - `duty_wr` at cycle N: ALIGN at N+1.
  - The first `period_end` at cycle M ≥ N+1 gives `duty_out` updated at M+1, with `done` high at M+1 only.
- Ramp mode: each step takes eff_div cycles in RAMP plus the wait in ALIGN for the next `period_end`.
- `busy` rises the cycle after the accepted `duty_wr` and falls with the `done` cycle.
- Reset asserted in any state:
  - Next cycle all registers hold reset values.
  - Pending steps are dropped; no `done` pulse.

## Structure
- Package `pwm_ctrl_pkg`:
  - State enum (IDLE, RAMP, ALIGN).
  - Default `DUTY_W`/`DIV_W` constants, shared with the PWM and SPI blocks.
- Sub-module `step_prescaler`:
  - Contains the `div_cnt` counter with clear and enable.
  - Outputs a one-cycle `tick` at eff_div−1.
- Step arithmetic and FSM stay in the top module.

## Test plan
1. **Reset:**
   - Assert `rst` 2 cycles with `RESET_DUTY`=0 → `duty_out`=0x00, `busy`=0, `done`=0.
   - Assert `rst` with `duty_wr` held high → still IDLE.
2. **Jump:**
   - Stimulus: `ramp_en`=0, `duty_wdata`=0x80, `period_end` every 8 cycles.
   - Response: `duty_out`=0x80 exactly one cycle after the first `period_end` following the write; single `done` pulse.
3. **Ramp up:**
   - Stimulus: from 0x00 with `step_size`=0x10, `step_div`=3, target 0x30.
   - Response: `duty_out` 0x10 → 0x20 → 0x30, each change one cycle after a `period_end`; `done` once, after 0x30.
4. **Ramp down with saturation:**
   - Stimulus: from 0x30, target 0x05, `step_size`=0x10.
   - Response: 0x20 → 0x10 → 0x05; never 0x00 or wrap.
   - `step_size`=0, `step_div`=0 → steps of 1, one step per period.
5. **Retarget and simultaneous events:**
   - Mid-ramp, from 0x00 toward 0x30 with `step_size`=0x10, after `duty_out`=0x10: write 0x00 in ALIGN on the same cycle as `period_end` → commit 0x20, then ramp 0x10 → 0x00, one `done` total.
   - Write equal to `duty_out` in IDLE → no `busy`, no `done`.
6. **Reset mid-operation:**
   - Assert `rst` in ALIGN with `next_duty`=0x40 → `duty_out`=0x00, IDLE, `busy`=0.
   - Later `period_end` → no change.
